// File: rtl/anabellek_hakemi.sv
// Main-memory arbiter between the fetch and data-cache ports; one transaction outstanding at a time.
// Define ANABELLEK_HAKEM_DONUSUMLU_EN for round-robin arbitration; the default is fixed data-first priority.
module anabellek_hakemi #(
  parameter int OBEK_BIT    = 128,
  parameter int ZAMAN_ASIMI = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                getir_istek_i,
  input  logic [31:0]         getir_adres_i,
  input  logic                getir_iptal_i,
  output logic                getir_musait_o,
  output logic                getir_veri_hazir_o,
  output logic [OBEK_BIT-1:0] getir_obek_o,
  input  logic                bellek_istek_i,
  input  logic [31:0]         bellek_adres_i,
  input  logic                bellek_yaz_i,
  input  logic [OBEK_BIT-1:0] bellek_yaz_obek_i,
  output logic                bellek_musait_o,
  output logic                bellek_veri_hazir_o,
  output logic [OBEK_BIT-1:0] bellek_obek_o,
  output logic                ab_istek_o,
  output logic [31:0]         ab_adres_o,
  output logic                ab_yaz_o,
  output logic                ab_oku_o,
  output logic [OBEK_BIT-1:0] ab_yaz_obek_o,
  input  logic                ab_kabul_i,
  input  logic                ab_hazir_i,
  input  logic [OBEK_BIT-1:0] ab_obek_i,
  output logic                zaman_asimi_o
);

  localparam int SW = (ZAMAN_ASIMI < 2) ? 1 : $clog2(ZAMAN_ASIMI + 1);
  localparam logic [SW-1:0] SINIR = SW'(ZAMAN_ASIMI);

  typedef enum logic [1:0] {BOSTA, ISTEK, CEVAP} durum_t;

  durum_t              durum_q, durum_d;
  logic [31:0]         adres_q, adres_d;
  logic                yaz_q, yaz_d;
  logic [OBEK_BIT-1:0] yobek_q, yobek_d;
  logic                sahip_q, sahip_d;   // 1: fetch owns the transaction
  logic                iptal_q, iptal_d;
  logic [SW-1:0]       sayac_q, sayac_d;
  logic                zaman_q, zaman_d;
  logic                ghazir_q, ghazir_d;
  logic                bhazir_q, bhazir_d;
  logic [OBEK_BIT-1:0] gobek_q, gobek_d;
  logic [OBEK_BIT-1:0] bobek_q, bobek_d;
  logic                getir_kazanir;
  logic                dusur;

`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
  logic rr_q, rr_d;  // 1: fetch has priority on a tie
  assign getir_kazanir = getir_istek_i && (!bellek_istek_i || rr_q);
`else
  assign getir_kazanir = getir_istek_i && !bellek_istek_i;
`endif

  always_comb begin
    durum_d  = durum_q;
    adres_d  = adres_q;
    yaz_d    = yaz_q;
    yobek_d  = yobek_q;
    sahip_d  = sahip_q;
    iptal_d  = iptal_q;
    sayac_d  = sayac_q;
    zaman_d  = zaman_q;
    ghazir_d = 1'b0;
    bhazir_d = 1'b0;
    gobek_d  = gobek_q;
    bobek_d  = bobek_q;
    dusur    = iptal_q || (getir_iptal_i && sahip_q);
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
    rr_d     = rr_q;
`endif
    case (durum_q)
      BOSTA: begin
        if (getir_istek_i || bellek_istek_i) begin
          durum_d = ISTEK;
          iptal_d = 1'b0;
          if (getir_kazanir) begin
            sahip_d = 1'b1;
            adres_d = getir_adres_i;
            yaz_d   = 1'b0;
            yobek_d = '0;
          end else begin
            sahip_d = 1'b0;
            adres_d = bellek_adres_i;
            yaz_d   = bellek_yaz_i;
            yobek_d = bellek_yaz_obek_i;
          end
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
          rr_d = !getir_kazanir;
`endif
        end
      end
      ISTEK: begin
        if (sahip_q && getir_iptal_i) iptal_d = 1'b1;
        if (ab_kabul_i) begin
          durum_d = CEVAP;
          sayac_d = '0;
        end
      end
      CEVAP: begin
        if (sahip_q) iptal_d = dusur;
        if (ab_hazir_i) begin
          durum_d = BOSTA;
          iptal_d = 1'b0;
          if (sahip_q) begin
            if (!dusur) begin
              gobek_d  = ab_obek_i;
              ghazir_d = 1'b1;
            end
          end else begin
            bobek_d  = ab_obek_i;
            bhazir_d = 1'b1;
          end
        end else begin
          if (sayac_q != SINIR) sayac_d = sayac_q + 1'b1;
          if (sayac_d == SINIR) zaman_d = 1'b1;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum_q  <= BOSTA;
      adres_q  <= '0;
      yaz_q    <= 1'b0;
      yobek_q  <= '0;
      sahip_q  <= 1'b0;
      iptal_q  <= 1'b0;
      sayac_q  <= '0;
      zaman_q  <= 1'b0;
      ghazir_q <= 1'b0;
      bhazir_q <= 1'b0;
      gobek_q  <= '0;
      bobek_q  <= '0;
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
      rr_q     <= 1'b1;
`endif
    end else begin
      durum_q  <= durum_d;
      adres_q  <= adres_d;
      yaz_q    <= yaz_d;
      yobek_q  <= yobek_d;
      sahip_q  <= sahip_d;
      iptal_q  <= iptal_d;
      sayac_q  <= sayac_d;
      zaman_q  <= zaman_d;
      ghazir_q <= ghazir_d;
      bhazir_q <= bhazir_d;
      gobek_q  <= gobek_d;
      bobek_q  <= bobek_d;
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
      rr_q     <= rr_d;
`endif
    end
  end

  assign getir_musait_o      = (durum_q == BOSTA);
  assign bellek_musait_o     = (durum_q == BOSTA);
  assign ab_istek_o          = (durum_q == ISTEK);
  assign ab_yaz_o            = ab_istek_o && yaz_q;
  assign ab_oku_o            = ab_istek_o && !yaz_q;
  assign ab_adres_o          = adres_q;
  assign ab_yaz_obek_o       = yobek_q;
  assign getir_veri_hazir_o  = ghazir_q;
  assign bellek_veri_hazir_o = bhazir_q;
  assign getir_obek_o        = gobek_q;
  assign bellek_obek_o       = bobek_q;
  assign zaman_asimi_o       = zaman_q;

endmodule

// File: tb/tb_anabellek_hakemi.sv
// Directed bench for anabellek_hakemi: vector table of single transactions plus
// hand-written sequences for arbitration, cancel, timeout and mid-transaction reset.
module tb_anabellek_hakemi;
  localparam int OB = 128;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          getir_istek_i, getir_iptal_i, getir_musait_o, getir_veri_hazir_o;
  logic [31:0]   getir_adres_i;
  logic [OB-1:0] getir_obek_o;
  logic          bellek_istek_i, bellek_yaz_i, bellek_musait_o, bellek_veri_hazir_o;
  logic [31:0]   bellek_adres_i;
  logic [OB-1:0] bellek_yaz_obek_i, bellek_obek_o;
  logic          ab_istek_o, ab_yaz_o, ab_oku_o, ab_kabul_i, ab_hazir_i, zaman_asimi_o;
  logic [31:0]   ab_adres_o;
  logic [OB-1:0] ab_yaz_obek_o, ab_obek_i;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  anabellek_hakemi #(.OBEK_BIT(OB), .ZAMAN_ASIMI(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .getir_istek_i(getir_istek_i), .getir_adres_i(getir_adres_i), .getir_iptal_i(getir_iptal_i),
    .getir_musait_o(getir_musait_o), .getir_veri_hazir_o(getir_veri_hazir_o), .getir_obek_o(getir_obek_o),
    .bellek_istek_i(bellek_istek_i), .bellek_adres_i(bellek_adres_i), .bellek_yaz_i(bellek_yaz_i),
    .bellek_yaz_obek_i(bellek_yaz_obek_i), .bellek_musait_o(bellek_musait_o),
    .bellek_veri_hazir_o(bellek_veri_hazir_o), .bellek_obek_o(bellek_obek_o),
    .ab_istek_o(ab_istek_o), .ab_adres_o(ab_adres_o), .ab_yaz_o(ab_yaz_o), .ab_oku_o(ab_oku_o),
    .ab_yaz_obek_o(ab_yaz_obek_o), .ab_kabul_i(ab_kabul_i), .ab_hazir_i(ab_hazir_i),
    .ab_obek_i(ab_obek_i), .zaman_asimi_o(zaman_asimi_o)
  );

  typedef struct {
    logic          gi;
    logic [31:0]   ga;
    logic          bi;
    logic [31:0]   ba;
    logic          by;
    logic [OB-1:0] bo;
    logic [OB-1:0] mo;
    int            kd;
    int            hd;
    logic          e_getir;
    logic [31:0]   e_adres;
    logic          e_yaz;
  } vek_t;

  vek_t tablo[5];

  task automatic chk(input string ad, input logic [OB-1:0] gercek, input logic [OB-1:0] beklenen);
    n_cmp++;
    if (gercek !== beklenen) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", ad, gercek, beklenen);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input vek_t v, input int idx);
    getir_istek_i = v.gi; getir_adres_i = v.ga;
    bellek_istek_i = v.bi; bellek_adres_i = v.ba; bellek_yaz_i = v.by; bellek_yaz_obek_i = v.bo;
    chk($sformatf("v%0d musait", idx), {getir_musait_o, bellek_musait_o}, 2'b11);
    tick();
    getir_istek_i = 1'b0; bellek_istek_i = 1'b0;
    chk($sformatf("v%0d ab_istek", idx), ab_istek_o, 1'b1);
    chk($sformatf("v%0d ab_adres", idx), ab_adres_o, v.e_adres);
    chk($sformatf("v%0d yaz/oku", idx), {ab_yaz_o, ab_oku_o}, {v.e_yaz, !v.e_yaz});
    if (v.e_yaz) chk($sformatf("v%0d yaz_obek", idx), ab_yaz_obek_o, v.bo);
    repeat (v.kd) begin
      tick();
      chk($sformatf("v%0d istek held", idx), {ab_istek_o, ab_adres_o}, {1'b1, v.e_adres});
    end
    ab_kabul_i = 1'b1;
    tick();
    ab_kabul_i = 1'b0;
    chk($sformatf("v%0d strobes off", idx), {ab_istek_o, ab_yaz_o, ab_oku_o}, 3'b000);
    repeat (v.hd) begin
      tick();
      chk($sformatf("v%0d no early pulse", idx), {getir_veri_hazir_o, bellek_veri_hazir_o}, 2'b00);
    end
    ab_hazir_i = 1'b1; ab_obek_i = v.mo;
    tick();
    ab_hazir_i = 1'b0;
    chk($sformatf("v%0d pulse", idx), {getir_veri_hazir_o, bellek_veri_hazir_o}, {v.e_getir, !v.e_getir});
    if (!v.e_yaz) chk($sformatf("v%0d obek", idx), v.e_getir ? getir_obek_o : bellek_obek_o, v.mo);
    tick();
    chk($sformatf("v%0d pulse end", idx), {getir_veri_hazir_o, bellek_veri_hazir_o}, 2'b00);
    if (!v.e_yaz) chk($sformatf("v%0d obek held", idx), v.e_getir ? getir_obek_o : bellek_obek_o, v.mo);
  endtask

  initial begin
    logic rr_mode;
    logic exp_g;
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
    rr_mode = 1'b1;
`else
    rr_mode = 1'b0;
`endif
    tablo[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0, 1'b0, '0, {16{8'hA5}}, 0, 3, 1'b1, 32'h0000_1000, 1'b0};
    tablo[1] = '{1'b0, 32'h0, 1'b1, 32'h0000_2040, 1'b1, {8{16'h1234}}, '0, 2, 1, 1'b0, 32'h0000_2040, 1'b1};
    tablo[2] = '{1'b0, 32'h0, 1'b1, 32'h0000_3000, 1'b0, {4{32'hFFFF_0000}}, {4{32'hDEAD_BEEF}}, 1, 0, 1'b0, 32'h0000_3000, 1'b0};
`ifdef ANABELLEK_HAKEM_DONUSUMLU_EN
    tablo[3] = '{1'b1, 32'h0000_4000, 1'b1, 32'h0000_5000, 1'b0, '0, {4{32'h0BAD_F00D}}, 0, 2, 1'b1, 32'h0000_4000, 1'b0};
`else
    tablo[3] = '{1'b1, 32'h0000_4000, 1'b1, 32'h0000_5000, 1'b0, '0, {4{32'h0BAD_F00D}}, 0, 2, 1'b0, 32'h0000_5000, 1'b0};
`endif
    tablo[4] = '{1'b1, 32'h0000_6000, 1'b0, 32'h0, 1'b0, '0, {8{16'h5A3C}}, 0, 0, 1'b1, 32'h0000_6000, 1'b0};

    rst_i = 1'b0;
    getir_istek_i = 0; getir_adres_i = 0; getir_iptal_i = 0;
    bellek_istek_i = 0; bellek_adres_i = 0; bellek_yaz_i = 0; bellek_yaz_obek_i = '0;
    ab_kabul_i = 0; ab_hazir_i = 0; ab_obek_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset musait", {getir_musait_o, bellek_musait_o}, 2'b11);
    chk("reset strobes", {ab_istek_o, ab_yaz_o, ab_oku_o, getir_veri_hazir_o, bellek_veri_hazir_o, zaman_asimi_o}, 6'b0);
    chk("reset adres", ab_adres_o, 32'h0);
    chk("reset getir_obek", getir_obek_o, '0);
    chk("reset bellek_obek", bellek_obek_o, '0);
    @(negedge clk_i) rst_i = 1'b1;
    tick();

    // both requesters held high for four back-to-back transactions
    getir_istek_i = 1; getir_adres_i = 32'h100;
    bellek_istek_i = 1; bellek_adres_i = 32'h200; bellek_yaz_i = 0;
    for (int k = 0; k < 4; k++) begin
      exp_g = rr_mode && (k % 2 == 0);
      tick();
      chk($sformatf("arb%0d adres", k), ab_adres_o, exp_g ? 32'h100 : 32'h200);
      ab_kabul_i = 1;
      tick();
      ab_kabul_i = 0; ab_hazir_i = 1; ab_obek_i = OB'(k + 1);
      tick();
      ab_hazir_i = 0;
      chk($sformatf("arb%0d pulse", k), {getir_veri_hazir_o, bellek_veri_hazir_o}, {exp_g, !exp_g});
    end
    getir_istek_i = 0; bellek_istek_i = 0;
    tick();
    chk("arb idle", {getir_musait_o, ab_istek_o}, 2'b10);

    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(tablo[i], i);

    // kabul/hazir while idle must be ignored
    ab_kabul_i = 1; ab_hazir_i = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("idle ignore", {ab_istek_o, getir_veri_hazir_o, bellek_veri_hazir_o, getir_musait_o}, 4'b0001);
    end
    ab_kabul_i = 0; ab_hazir_i = 0;

    // fetch cancelled while waiting for the response
    getir_istek_i = 1; getir_adres_i = 32'h8000;
    tick();
    getir_istek_i = 0; ab_kabul_i = 1;
    tick();
    ab_kabul_i = 0; getir_iptal_i = 1;
    tick();
    getir_iptal_i = 0; ab_hazir_i = 1; ab_obek_i = {4{32'h1111_2222}};
    tick();
    ab_hazir_i = 0;
    chk("drop no pulse", {getir_veri_hazir_o, getir_musait_o}, 2'b01);
    bellek_istek_i = 1; bellek_adres_i = 32'h9000; bellek_yaz_i = 0;
    tick();
    bellek_istek_i = 0;
    chk("after drop accept", {ab_istek_o, ab_adres_o}, {1'b1, 32'h9000});
    ab_kabul_i = 1;
    tick();
    ab_kabul_i = 0; getir_iptal_i = 1;
    tick();
    getir_iptal_i = 0; ab_hazir_i = 1; ab_obek_i = {4{32'h3333_4444}};
    tick();
    ab_hazir_i = 0;
    chk("iptal data pulse", bellek_veri_hazir_o, 1'b1);
    chk("iptal data obek", bellek_obek_o, {4{32'h3333_4444}});

    // cancel asserted in BOSTA has no effect on the fetch that follows
    getir_iptal_i = 1; getir_istek_i = 1; getir_adres_i = 32'hA000;
    tick();
    getir_iptal_i = 0; getir_istek_i = 0; ab_kabul_i = 1;
    tick();
    ab_kabul_i = 0; ab_hazir_i = 1; ab_obek_i = {4{32'h5555_6666}};
    tick();
    ab_hazir_i = 0;
    chk("iptal idle pulse", {getir_veri_hazir_o, getir_obek_o}, {1'b1, {4{32'h5555_6666}}});

    // response withheld 300 cycles
    getir_istek_i = 1; getir_adres_i = 32'h7000;
    tick();
    getir_istek_i = 0; ab_kabul_i = 1;
    tick();
    ab_kabul_i = 0;
    repeat (254) tick();
    chk("timeout 254", zaman_asimi_o, 1'b0);
    tick();
    chk("timeout 255", zaman_asimi_o, 1'b1);
    repeat (45) tick();
    chk("timeout sticky", {zaman_asimi_o, getir_musait_o}, 2'b10);
    ab_hazir_i = 1; ab_obek_i = {4{32'h7777_8888}};
    tick();
    ab_hazir_i = 0;
    chk("late pulse", {getir_veri_hazir_o, getir_obek_o}, {1'b1, {4{32'h7777_8888}}});
    tick();
    chk("timeout after", zaman_asimi_o, 1'b1);

    // reset while a request is pending
    getir_istek_i = 1; getir_adres_i = 32'hB000;
    tick();
    getir_istek_i = 0;
    chk("pre-reset istek", ab_istek_o, 1'b1);
    #2 rst_i = 1'b0;
    #1;
    chk("async reset", {ab_istek_o, getir_musait_o, zaman_asimi_o}, 3'b010);
    @(negedge clk_i) rst_i = 1'b1;
    ab_kabul_i = 1; ab_hazir_i = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post-reset quiet", {ab_istek_o, getir_veri_hazir_o, bellek_veri_hazir_o}, 3'b000);
    end
    ab_kabul_i = 0; ab_hazir_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
